data_memory_ctrl: RTL and testbench

//   Parametrised data memory for the single-cycle datapath. Replaces the fixed 32x32 array.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/data_memory_ctrl.sv | 104 ++++++++++
 tb/tb_data_memory_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and the preload table for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } dmem_store_t;

  // Words past the table are cleared to zero.
  function automatic logic [31:0] init_word(input int unsigned i);
    logic [31:0] w;
    case (i)
      0:       w = 32'd7;
      1:       w = 32'd8;
      2:       w = 32'd1;
      3:       w = 32'd9;
      4:       w = 32'd2;
      5:       w = 32'd6;
      6:       w = 32'd3;
      7:       w = 32'd10;
      8:       w = 32'd4;
      9:       w = 32'd5;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: load select/extend, store byte enables and
// replicated store data, plus the raw alignment fault for the access size.
module dmem_lane_align import dmem_pkg::*; (
  input  mem_size_e    size,
  input  logic         is_unsigned,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  rd_word,
  input  logic [31:0]  wr_data,
  output logic [31:0]  load_data,
  output dmem_store_t  st,
  output logic         align_fault
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = rd_word[{addr_lo, 3'b000} +: 8];
  assign hsel = rd_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data   = '0;
    st.be       = '0;
    st.data     = '0;
    align_fault = 1'b0;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & bsel[7]}}, bsel};
        st.be     = 4'b0001 << addr_lo;
        st.data   = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        load_data   = {{16{~is_unsigned & hsel[15]}}, hsel};
        st.be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st.data     = {2{wr_data[15:0]}};
        align_fault = addr_lo[0];
      end
      SZ_WORD: begin
        load_data   = rd_word;
        st.be       = 4'b1111;
        st.data     = wr_data;
        align_fault = |addr_lo;
      end
      default: align_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory with byte/half/word access and a post-reset clear/preload sweep.
// Optional debug read tap enabled by defining DMEM_DEBUG_TAP_EN.
module data_memory_ctrl import dmem_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int INIT_WORDS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              misaligned
`ifdef DMEM_DEBUG_TAP_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] dbg_index,
  output logic [DATA_W-1:0]        dbg_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  dmem_state_e state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          ready_q, ready_d;

  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] load_data;
  dmem_store_t       st;
  logic              align_fault;
  logic              store_en;
  logic              unused_addr_hi;

  // Upper address bits are dropped so the word index wraps modulo DEPTH.
  assign idx            = address[AW+1:2];
  assign unused_addr_hi = ^address[31:AW+2];

  dmem_lane_align u_align (
    .size        (mem_size_e'(mem_size)),
    .is_unsigned (mem_unsigned),
    .addr_lo     (address[1:0]),
    .rd_word     (mem[idx]),
    .wr_data     (write_data),
    .load_data   (load_data),
    .st          (st),
    .align_fault (align_fault)
  );

  assign misaligned = (mem_read | mem_write) & ready_q & align_fault;
  assign read_data  = (mem_read & ready_q & ~align_fault) ? load_data : '0;
  assign ready      = ready_q;
  assign store_en   = mem_write & ready_q & ~align_fault;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
    end
  end

  // No reset on the array; gating on reset_n keeps contents intact while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == ST_CLEAR) begin
      mem[sweep_q] <= (32'(sweep_q) < INIT_WORDS) ? init_word(32'(sweep_q)) : '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st.be[b]) mem[idx][b*8 +: 8] <= st.data[b*8 +: 8];
      end
    end
  end

`ifdef DMEM_DEBUG_TAP_EN
  assign dbg_data = mem[dbg_index];
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized + directed bench for data_memory_ctrl against a behavioural word-array model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;
  localparam int INITW = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        misaligned;

  int n_chk = 0;
  int n_pass = 0;

  data_memory_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .INIT_WORDS(INITW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  // ---- behavioural model ----
  int          init_tab [INITW] = '{7, 8, 1, 9, 2, 6, 3, 10, 4, 5};
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;   // clock edges since reset release

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic m_mis(input logic r, input logic w, input logic [1:0] sz,
                                 input logic [31:0] a, input logic rdy);
    logic bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    return (r || w) && rdy && bad;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] sz,
                                         input logic u, input logic [31:0] a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (word >> (int'(a[1:0]) * 8)) & 32'hFF;
        if (!u) v = (v ^ 32'h80) - 32'h80;
      end
      2'd1: begin
        v = (word >> (int'(a[1]) * 16)) & 32'hFFFF;
        if (!u) v = (v ^ 32'h8000) - 32'h8000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    case (sz)
      2'd0:    begin sh = int'(a[1:0]) * 8; mask = 32'hFF << sh; end
      2'd1:    begin sh = int'(a[1]) * 16;  mask = 32'hFFFF << sh; end
      default: begin sh = 0;                mask = 32'hFFFF_FFFF; end
    endcase
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else if (cyc < DEPTH) begin
      mdl[cyc] <= (cyc < INITW) ? 32'(init_tab[cyc]) : 32'd0;
      cyc <= cyc + 1;
    end else if (mem_write && !m_mis(mem_read, mem_write, mem_size, address, 1'b1))
      mdl[widx(address)] <= m_store(mdl[widx(address)], mem_size, address, write_data);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  logic        e_rdy, e_mis;
  logic [31:0] e_rd;
  always @(negedge clk) begin
    e_rdy = reset_n && cyc >= DEPTH;
    e_mis = m_mis(mem_read, mem_write, mem_size, address, e_rdy);
    e_rd  = (mem_read && e_rdy && !e_mis) ?
            m_load(mdl[widx(address)], mem_size, mem_unsigned, address) : 32'd0;
    chk("ready", {31'd0, ready}, {31'd0, e_rdy});
    chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
    chk("read_data", read_data, e_rd);
  end

  // ---- stimulus ----
  task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    mem_read = r; mem_write = w; mem_size = sz; mem_unsigned = u;
    address = a; write_data = wd;
  endtask

  task automatic wait_ready_exact(input string nm);
    repeat (DEPTH - 1) @(posedge clk);
    @(negedge clk); chk({nm, "_low"}, {31'd0, ready}, 32'd0);
    @(posedge clk);
    @(negedge clk); chk({nm, "_high"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // sweep length and preload
    wait_ready_exact("t1_ready");
    op(1, 0, 2'd2, 0, 32'd0, 0);  @(negedge clk); chk("lw0", read_data, 32'd7);
    op(1, 0, 2'd2, 0, 32'd36, 0); @(negedge clk); chk("lw36", read_data, 32'd5);
    op(1, 0, 2'd2, 0, 32'd40, 0); @(negedge clk); chk("lw40", read_data, 32'd0);

    // byte store/load
    op(0, 1, 2'd0, 0, 32'd5, 32'hAB);
    op(1, 0, 2'd2, 0, 32'd4, 0); @(negedge clk); chk("sb_word1", read_data, 32'h0000AB08);
    op(1, 0, 2'd0, 0, 32'd5, 0); @(negedge clk); chk("lb5", read_data, 32'hFFFFFFAB);
    op(1, 0, 2'd0, 1, 32'd5, 0); @(negedge clk); chk("lbu5", read_data, 32'h000000AB);

    // half store/load
    op(0, 1, 2'd1, 0, 32'd2, 32'h8001);
    op(1, 0, 2'd2, 0, 32'd0, 0); @(negedge clk); chk("sh_word0", read_data, 32'h80010007);
    op(1, 0, 2'd1, 0, 32'd2, 0); @(negedge clk); chk("lh2", read_data, 32'hFFFF8001);
    op(1, 0, 2'd1, 1, 32'd2, 0); @(negedge clk); chk("lhu2", read_data, 32'h00008001);

    // misalignment
    op(0, 1, 2'd2, 0, 32'd6, 32'h55); @(negedge clk);
    chk("sw6_mis", {31'd0, misaligned}, 32'd1);
    op(1, 0, 2'd3, 0, 32'd0, 0); @(negedge clk);
    chk("rsvd_mis", {31'd0, misaligned}, 32'd1); chk("rsvd_rd", read_data, 32'd0);
    op(1, 0, 2'd2, 0, 32'd4, 0); @(negedge clk); chk("mis_nochg", read_data, 32'h0000AB08);

    // wrap and same-cycle load/store
    op(1, 0, 2'd2, 0, 32'd64, 0); @(negedge clk); chk("wrap64", read_data, 32'h80010007);
    op(1, 1, 2'd2, 0, 32'd12, 32'hDEADBEEF); @(negedge clk); chk("rw_old", read_data, 32'd9);
    op(1, 0, 2'd2, 0, 32'd12, 0); @(negedge clk); chk("rw_new", read_data, 32'hDEADBEEF);

    // random traffic, checked every cycle by the compare process
    repeat (600) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // reset in mid-sweep; store during sweep is dropped
    op(0, 0, 2'd2, 0, 0, 0);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    mem_write = 1'b1; mem_size = 2'd2; address = 32'd12; write_data = 32'h12345678;
    repeat (5) @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    wait_ready_exact("t5_ready");
    #1 mem_write = 1'b0;
    op(1, 0, 2'd2, 0, 32'd12, 0); @(negedge clk); chk("sweep_sw_lost", read_data, 32'd9);
    op(1, 0, 2'd2, 0, 32'd64, 0); @(negedge clk); chk("reswept_w0", read_data, 32'd7);
    op(0, 0, 2'd2, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
